// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: asserts all domain resets, holds them, then releases domains one at a time in ascending order
module reset_release_sequencer #(
  parameter int N_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_req,
  input  logic [N_DOMAINS-1:0] io_ack,
  output logic [N_DOMAINS-1:0] io_rst,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_timeout
);
  localparam int KW = N_DOMAINS > 1 ? $clog2(N_DOMAINS) : 1;
  localparam int CMAX = HOLD_CYCLES > ACK_TIMEOUT ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int CW = $clog2(CMAX);
  localparam logic [KW-1:0] K_LAST = KW'(N_DOMAINS - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ACK_END = CW'(ACK_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ASSERT, HOLD, RELEASE, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [N_DOMAINS-1:0] rst_q, rst_d;
  logic busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic ack_all, ack_k, expired;
  // one counter serves both the ack-wait timer and the hold timer
  always_comb begin
    ack_all = &io_ack;
    ack_k = io_ack[k_q];
    expired = cnt_q == ACK_END;
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    k_d = k_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        k_d = '0;
        if (io_req) begin
          state_d = ASSERT;
          timeout_d = 1'b0;
        end
      end
      ASSERT:
        if (ack_all || expired) begin
          state_d = HOLD;
          cnt_d = '0;
          timeout_d = timeout_q | ~ack_all;
        end
      HOLD:
        if (io_req) cnt_d = '0;
        else if (cnt_q == HOLD_END) begin
          state_d = RELEASE;
          cnt_d = '0;
          k_d = '0;
        end
      RELEASE:
        if (io_req) begin
          state_d = ASSERT;
          cnt_d = '0;
          k_d = '0;
        end else if (!ack_k || expired) begin
          timeout_d = timeout_q | ack_k;
          cnt_d = '0;
          if (k_q == K_LAST) state_d = DONE;
          else k_d = k_q + KW'(1);
        end
      DONE: begin
        state_d = io_req ? ASSERT : IDLE;
        cnt_d = '0;
        k_d = '0;
      end
      default: state_d = ASSERT;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    for (int i = 0; i < N_DOMAINS; i++)
      rst_d[i] = state_d == ASSERT || state_d == HOLD || (state_d == RELEASE && i > int'(k_d));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ASSERT;
      cnt_q <= '0;
      k_q <= '0;
      rst_q <= '1;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      rst_q <= rst_d;
      busy_q <= busy_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
    end
  end
  assign io_rst = rst_q;
  assign io_busy = busy_q;
  assign io_done = done_q;
  assign io_timeout = timeout_q;
endmodule

// File: doc/reset_release_sequencer.md
Name: reset_release_sequencer

Overview:
- Source end of the reset-synchronizer crossing. Generates per-domain reset levels that feed the downstream reset synchronizer shift registers.
- Sequences assertion, minimum hold and ordered release across N_DOMAINS.
- Closes the loop on per-domain acknowledgements returned from each synchronized domain.
- Sits in the always-on clock domain next to the top-level reset controller.

Parameters:
- N_DOMAINS, 3, number of downstream reset domains; index 0 is released first.
- HOLD_CYCLES, 16, minimum cycles all resets stay asserted after all acks are seen; legal range >= 1.
- ACK_TIMEOUT, 64, maximum cycles spent waiting for any single ack condition before proceeding; legal range >= 2.

Ports:
- clock, input, 1, sole clock.
- reset, input, 1, synchronous, active-high.
- io_req, input, 1, reset request; sampled each cycle; a 1 requests a full reset sequence.
- io_ack, input, N_DOMAINS, per-domain in-reset status already synchronized into clock; 1 means the domain is in reset.
- io_rst, output, N_DOMAINS, per-domain reset level driven to the domain synchronizers; 1 means asserted.
- io_busy, output, 1, high whenever the FSM is not in IDLE.
- io_done, output, 1, single-cycle pulse on completion of a sequence.
- io_timeout, output, 1, sticky; set when any ack wait expires.

Behaviour:
- Interface: one clock, clock. reset is synchronous and active-high. All state updates on the rising edge of clock.
- Reset values: FSM=ASSERT, io_rst=all ones, io_busy=1, io_done=0, io_timeout=0, counters=0. A power-on reset therefore runs a full sequence with no io_req needed.
- State IDLE:
  - io_rst=0, io_busy=0.
  - io_req=1 -> ASSERT next cycle, with io_rst=all ones registered in that same edge.
  - Accepting io_req in IDLE clears io_timeout.
- State ASSERT:
  - io_rst=all ones.
  - Wait until io_ack==all ones, then -> HOLD with hold counter=0.
  - The wait counter increments each cycle. When it reaches ACK_TIMEOUT-1 and acks are still incomplete, set io_timeout and -> HOLD anyway.
- State HOLD:
  - io_rst=all ones; the hold counter increments.
  - When the counter reaches HOLD_CYCLES-1 -> RELEASE with domain index k=0 and the wait counter cleared.
  - io_req=1 in HOLD restarts the hold counter at 0 and stays in HOLD.
- State RELEASE:
  - io_rst[i]=0 for all i<=k; io_rst[i]=1 for all i>k. Bit k drops on the cycle of entry.
  - Wait for io_ack[k]==0, or for the timeout (which sets io_timeout).
  - Then, if k==N_DOMAINS-1 -> DONE; otherwise k=k+1, clear the wait counter, and stay in RELEASE.
  - Wait counter and k are sized by clog2; k never exceeds N_DOMAINS-1.
- State DONE:
  - io_rst=0, io_done=1 for exactly this cycle, io_busy=1.
  - Then -> IDLE.
- io_req during ASSERT: ignored; the sequence is already in progress.
- io_req during RELEASE or DONE: abort to ASSERT next cycle.
  - io_rst returns to all ones; no io_done pulse is produced.
  - io_timeout is not cleared.
- io_req in IDLE on the same cycle that reset is high: reset wins.
- Ack glitches:
  - An ack that drops during HOLD has no effect.
  - Acks of already-released domains are ignored in RELEASE.
- Output registering: io_rst, io_busy and io_done are registered. io_rst has no combinational path from io_req or io_ack.
- Release order is strictly ascending by index. Two domains never deassert in the same cycle.
- Reset mid-operation: reset from any state returns to reset values the next cycle, and sequencing starts over from ASSERT.

Test Plan:
- Power-on: assert reset 2 cycles, then hold io_ack=111 and drop each bit 2 cycles after its io_rst falls. Required:
  - io_rst=111 throughout ASSERT and for 16 HOLD cycles.
  - Release order 110 -> 100 -> 000 (bit0 first), with each step 3 cycles apart.
  - io_done pulses once; io_busy falls the cycle after it.
  - io_timeout=0.
- Ack timeout: from IDLE, pulse io_req with io_ack stuck at 011. Required:
  - ASSERT lasts exactly 64 cycles.
  - io_timeout=1 and remains set after DONE.
  - The next io_req accepted in IDLE clears io_timeout.
- Abort during release: issue io_req while in RELEASE with k=1. Required:
  - io_rst returns to 111 on the next cycle; FSM is in ASSERT.
  - No io_done pulse; the full sequence then completes normally.
- Req during HOLD: pulse io_req at HOLD count 10. Required: the hold counter restarts, and HOLD lasts 11+16 cycles in total before the first release.
- Mid-sequence reset: assert reset during RELEASE k=2. Required:
  - Next cycle io_rst=111, io_busy=1, io_done=0, io_timeout=0.
  - Sequencing restarts from ASSERT.
- Parameter sweep: N_DOMAINS=1 with HOLD_CYCLES=1, and N_DOMAINS=5 with HOLD_CYCLES=1. Required: HOLD lasts exactly 1 cycle, the release order is correct, and k never goes out of range.
